slc3_mem_arbiter: RTL and testbench
===================================

Name: slc3_mem_arbiter

Overview:
- Shares the single SLC-3 memory port between two requesters: the CPU datapath (MAR/MDR path) and the program loader/debug port.
- Sequences each access as a fixed-length wait-state transaction and returns the read data.
- Decodes the memory-mapped I/O word at 0xFFFF locally: reads return the switches, writes update the hex display register.
- Sits between the SLC-3 datapath/ISDU and the on-chip memory.

Parameters:
- WAIT_CYCLES, 2, memory access cycles per transaction (1..15).
- MMIO_ADDR, 16'hFFFF, address decoded locally instead of going to memory.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  16  CPU address (MAR)
- cpu_wdata  in  16  CPU write data (MDR)
- cpu_ack  out  1  one-cycle completion pulse to CPU
- ld_req  in  1  loader request, level
- ld_we  in  1  loader write/read
- ld_addr  in  16  loader address
- ld_wdata  in  16  loader write data
- ld_ack  out  1  one-cycle completion pulse to loader
- rdata  out  16  read data, valid in the ack cycle, held until the next ack
- SW  in  10  switch inputs for MMIO reads
- hex_reg  out  16  MMIO display register driving HEX0..HEX3
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid by the last access cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset:
- Async reset forces state=IDLE.
- All outputs reset to 0: cpu_ack, ld_ack, rdata, hex_reg, mem_ce, mem_we, mem_addr, mem_wdata, busy.
- Grant register and wait counter reset to 0.
- Reset asserted mid-transaction aborts it: no ack, no hex_reg update; any memory write in flight is undefined.

States:
- IDLE
  - Samples requests. With no request, stays in IDLE.
  - Arbitration picks a winner and latches its we/addr/wdata.
  - Goes to MMIO when the latched address equals MMIO_ADDR, otherwise to ACCESS with counter=WAIT_CYCLES-1.
- ACCESS
  - Drives mem_ce=1, mem_addr/mem_wdata from the latch, and mem_we=latched we.
  - Decrements the counter each cycle. At counter==0 it captures mem_rdata (reads only) and goes to DONE.
  - Memory signals are held stable for exactly WAIT_CYCLES cycles.
- MMIO
  - One cycle, no memory activity.
  - Read: captures {6'b0,SW}.
  - Write: hex_reg<=latched wdata.
  - Goes to DONE.
- DONE
  - Pulses the granted requester's ack for one cycle; rdata is updated for reads only.
  - Returns to IDLE.

Latency (request first sampled in IDLE at cycle 0):
- Memory access: ack at cycle WAIT_CYCLES+1.
- MMIO access: ack at cycle 2.

Handshake and arbitration rules:
- Requesters deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Fixed priority: CPU beats loader on simultaneous requests.
- Requests arriving while busy wait. Inputs are only sampled in IDLE.
- No back-to-back transactions: there is at least one IDLE cycle between them.

Boundaries:
- Addresses 0x0000..0xFFFE go to memory; 0xFFFF goes to MMIO. There is no wrap logic.
- rdata is unchanged by writes.

Optional Feature:
SLC3_ARB_RR_EN:
- Defined: round-robin arbitration. On simultaneous requests, the requester not granted last wins. The last-grant bit resets to loader, so CPU wins first.
- Undefined: fixed CPU priority, and the loader can starve while the CPU requests continuously.

Decomposition:
- Package slc3_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, MMIO, DONE};
  - grant_t enum {GNT_CPU, GNT_LD};
  - MMIO_SW_HEX address constant 16'hFFFF.
- No sub-module is needed; the wait counter is inline.

Test Plan:
- Reset mid-ACCESS (Reset pulsed at cycle 1 of a CPU read) -> state IDLE, no cpu_ack, all outputs 0, busy=0.
- CPU read addr 0x3000, memory holds 0x1234, WAIT_CYCLES=2 -> mem_ce high for 2 cycles, cpu_ack at cycle 3, rdata=0x1234.
- Loader write 0x0200<=0xBEEF, then CPU read 0x0200 -> ld_ack pulses, then rdata=0xBEEF on cpu_ack.
- CPU write 0xFFFF<=0x00A5 -> no mem_ce, cpu_ack at cycle 2, hex_reg=0x00A5. CPU read 0xFFFF with SW=10'h3FF -> rdata=0x03FF.
- cpu_req and ld_req held high for 4 transactions -> fixed priority: 4 cpu_acks, 0 ld_acks. SLC3_ARB_RR_EN: order CPU, LD, CPU, LD.
- Loader request raised during a CPU ACCESS -> loader is served only after cpu_ack plus one IDLE cycle; busy stays high except during that IDLE cycle.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the current transaction
//   mem_req_t   : latched request payload (we/addr/wdata)
package slc3_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned SW_W   = 10;
    localparam int unsigned CNT_W  = 4;

    // Switch-read / hex-display word, decoded inside the arbiter
    localparam logic [ADDR_W-1:0] MMIO_SW_HEX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MMIO,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_LD
    } grant_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/slc3_mem_arbiter.sv
// Two-requester (CPU datapath / program loader) arbiter for the single SLC-3
// memory port. Each access runs as a fixed WAIT_CYCLES memory transaction;
// the MMIO word (switch read / hex display write) is served locally.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (level, held until cpu_ack)
//   cpu_ack                    one-cycle CPU completion pulse
//   ld_req/we/addr/wdata       loader request
//   ld_ack                     one-cycle loader completion pulse
//   rdata                      read data, valid in ack cycle, held to next read
//   SW                         switches returned by MMIO reads
//   hex_reg                    display register written by MMIO writes
//   mem_ce/we/addr/wdata       memory port
//   mem_rdata                  memory read data
//   busy                       high whenever the FSM is not IDLE
//
// Build option: SLC3_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; without it the CPU has fixed priority.
module slc3_mem_arbiter
    import slc3_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MMIO_ADDR   = MMIO_SW_HEX
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] rdata,
    input  logic [SW_W-1:0]   SW,
    output logic [DATA_W-1:0] hex_reg,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        r_state,     w_state_nxt;
    grant_t            r_gnt,       w_gnt_nxt;
    mem_req_t          r_req,       w_req_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic [DATA_W-1:0] r_hex,       w_hex_nxt;
    logic              r_cpu_ack,   w_cpu_ack_nxt;
    logic              r_ld_ack,    w_ld_ack_nxt;
    logic              r_mem_ce,    w_mem_ce_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_busy,      w_busy_nxt;

    grant_t            w_pick;
    mem_req_t          w_sel;
    logic              w_any_req;

    assign w_any_req = cpu_req | ld_req;

`ifdef SLC3_ARB_RR_EN
    // Last granted requester; starts at loader so the CPU wins the first tie.
    grant_t r_last;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_last <= GNT_LD;
        end else if (r_state == IDLE && w_any_req) begin
            r_last <= w_pick;
        end
    end

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        w_pick = cpu_req ? GNT_CPU : GNT_LD;
        if (cpu_req && ld_req) begin
            w_pick = (r_last == GNT_CPU) ? GNT_LD : GNT_CPU;
        end
    end
`else
    // Fixed priority: CPU always wins a tie.
    always_comb begin
        w_pick = cpu_req ? GNT_CPU : GNT_LD;
    end
`endif

    // Payload of the arbitration winner
    always_comb begin
        w_sel = (w_pick == GNT_CPU) ? '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata}
                                    : '{we: ld_we,  addr: ld_addr,  wdata: ld_wdata};
    end

    // State and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_CPU;
            r_req       <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_hex       <= '0;
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_req       <= w_req_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rdata     <= w_rdata_nxt;
            r_hex       <= w_hex_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_ld_ack    <= w_ld_ack_nxt;
            r_mem_ce    <= w_mem_ce_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next state; outputs are computed for the state being entered so the
    // registered copies line up with that state.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_req_nxt       = r_req;
        w_cnt_nxt       = r_cnt;
        w_rdata_nxt     = r_rdata;
        w_hex_nxt       = r_hex;
        w_cpu_ack_nxt   = 1'b0;
        w_ld_ack_nxt    = 1'b0;
        w_mem_ce_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_gnt_nxt = w_pick;
                    w_req_nxt = w_sel;
                    if (w_sel.addr == MMIO_ADDR) begin
                        w_state_nxt = MMIO;
                    end else begin
                        w_state_nxt     = ACCESS;
                        w_cnt_nxt       = CNT_LOAD;
                        w_mem_ce_nxt    = 1'b1;
                        w_mem_we_nxt    = w_sel.we;
                        w_mem_addr_nxt  = w_sel.addr;
                        w_mem_wdata_nxt = w_sel.wdata;
                    end
                end
            end

            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = DONE;
                    w_cpu_ack_nxt = (r_gnt == GNT_CPU);
                    w_ld_ack_nxt  = (r_gnt == GNT_LD);
                    if (!r_req.we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                end else begin
                    w_cnt_nxt       = r_cnt - CNT_W'(1);
                    w_mem_ce_nxt    = 1'b1;
                    w_mem_we_nxt    = r_req.we;
                    w_mem_addr_nxt  = r_req.addr;
                    w_mem_wdata_nxt = r_req.wdata;
                end
            end

            MMIO: begin
                w_state_nxt   = DONE;
                w_cpu_ack_nxt = (r_gnt == GNT_CPU);
                w_ld_ack_nxt  = (r_gnt == GNT_LD);
                if (r_req.we) begin
                    w_hex_nxt = r_req.wdata;
                end else begin
                    w_rdata_nxt = {(DATA_W - SW_W)'(0), SW};
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign cpu_ack   = r_cpu_ack;
    assign ld_ack    = r_ld_ack;
    assign rdata     = r_rdata;
    assign hex_reg   = r_hex;
    assign mem_ce    = r_mem_ce;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter (WAIT_CYCLES = 2).
// A simple word-array memory model sits on the memory port.
module tb_slc3_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_ack;
    logic        ld_req, ld_we;
    logic [15:0] ld_addr, ld_wdata;
    logic        ld_ack;
    logic [15:0] rdata;
    logic [9:0]  SW;
    logic [15:0] hex_reg;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;

`ifdef SLC3_ARB_RR_EN
    localparam logic [3:0] EXP_ORDER = 4'b1010;  // bit i = 1: ack i went to loader
    localparam int         EXP_CPU_N = 2;
`else
    localparam logic [3:0] EXP_ORDER = 4'b0000;
    localparam int         EXP_CPU_N = 4;
`endif

    slc3_mem_arbiter #(.WAIT_CYCLES(2), .MMIO_ADDR(16'hFFFF)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .rdata     (rdata),
        .SW        (SW),
        .hex_reg   (hex_reg),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: preloaded during reset, written on ce&we
    logic [15:0] mem [0:65535];
    always @(posedge Clk) begin
        if (Reset) begin
            mem[16'h3000] <= 16'h1234;
            mem[16'hFFFE] <= 16'h5A5A;
        end else if (mem_ce && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One handshake; lat = cycle of ack counted from the IDLE sampling cycle (0).
    task automatic run_xact(input logic is_ld, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, output int lat, output int ce_n,
                            output int we_n, output int other_n, output int bad_n);
        lat = 0; ce_n = 0; we_n = 0; other_n = 0; bad_n = 0;
        @(negedge Clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        if (is_ld) begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (mem_ce) begin
                ce_n++;
                if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) bad_n++;
            end
            if (mem_we) we_n++;
            if (is_ld ? cpu_ack : ld_ack) other_n++;
            if (is_ld ? ld_ack : cpu_ack) begin
                lat = k;
                break;
            end
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
    endtask

    task automatic xact_chk(input string tag, input logic is_ld, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input int exp_lat, input int exp_ce);
        int lat, ce_n, we_n, other_n, bad_n;
        run_xact(is_ld, we, addr, wdata, lat, ce_n, we_n, other_n, bad_n);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_ce_cycles"}, 32'(ce_n), 32'(exp_ce));
        check_eq({tag, "_we_cycles"}, 32'(we_n), we ? 32'(exp_ce) : 32'd0);
        check_eq({tag, "_wrong_ack"}, 32'(other_n), 32'd0);
        check_eq({tag, "_bus_values"}, 32'(bad_n), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {27'd0, cpu_ack, ld_ack, mem_ce, mem_we, busy}, 32'd0);
        check_eq({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
        check_eq({tag, "_hex"}, {16'd0, hex_reg}, 32'd0);
        check_eq({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check_eq({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    endtask

    initial begin
        int         ack_n, cpu_n, last_cyc;
        logic [3:0] order;
        logic [6:0] busy_mask;
        int         cpu_cyc, ld_cyc, ack_seen;

        Reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
        SW = 10'h000;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;

        // Plain CPU memory read
        xact_chk("cpu_rd_3000", 1'b0, 1'b0, 16'h3000, 16'h0000, 3, 2);
        check_eq("cpu_rd_3000_rdata", {16'd0, rdata}, 32'h1234);

        // Loader write, then CPU reads it back; writes leave rdata alone
        xact_chk("ld_wr_0200", 1'b1, 1'b1, 16'h0200, 16'hBEEF, 3, 2);
        check_eq("ld_wr_rdata_kept", {16'd0, rdata}, 32'h1234);
        xact_chk("cpu_rd_0200", 1'b0, 1'b0, 16'h0200, 16'h0000, 3, 2);
        check_eq("cpu_rd_0200_rdata", {16'd0, rdata}, 32'hBEEF);

        // MMIO write and read
        xact_chk("cpu_wr_mmio", 1'b0, 1'b1, 16'hFFFF, 16'h00A5, 2, 0);
        check_eq("mmio_hex", {16'd0, hex_reg}, 32'h00A5);
        check_eq("mmio_wr_rdata_kept", {16'd0, rdata}, 32'hBEEF);
        SW = 10'h3FF;
        xact_chk("cpu_rd_mmio", 1'b0, 1'b0, 16'hFFFF, 16'h0000, 2, 0);
        check_eq("mmio_rd_rdata", {16'd0, rdata}, 32'h03FF);
        check_eq("mmio_rd_hex_kept", {16'd0, hex_reg}, 32'h00A5);

        // Highest memory-mapped address still goes to memory
        xact_chk("ld_rd_fffe", 1'b1, 1'b0, 16'hFFFE, 16'h0000, 3, 2);
        check_eq("ld_rd_fffe_rdata", {16'd0, rdata}, 32'h5A5A);

        // Both requesters held high across four transactions
        @(negedge Clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 16'hFFFE;
        ack_n = 0; cpu_n = 0; last_cyc = 0; order = '0;
        for (int k = 1; k <= 40 && ack_n < 4; k++) begin
            @(negedge Clk);
            if (cpu_ack || ld_ack) begin
                order[ack_n] = ld_ack;
                if (cpu_ack) cpu_n++;
                check_eq($sformatf("hold_rdata_%0d", ack_n), {16'd0, rdata},
                         ld_ack ? 32'h5A5A : 32'h1234);
                if (ack_n > 0) check_eq($sformatf("hold_gap_%0d", ack_n), 32'(k - last_cyc), 32'd4);
                last_cyc = k;
                ack_n++;
            end
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        check_eq("hold_acks", 32'(ack_n), 32'd4);
        check_eq("hold_cpu_acks", 32'(cpu_n), 32'(EXP_CPU_N));
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("hold_order_%0d", i), {31'd0, order[i]}, {31'd0, EXP_ORDER[i]});
        end

        // Loader request raised during a CPU access
        @(negedge Clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        ld_we = 1'b0; ld_addr = 16'h0200;
        cpu_cyc = 0; ld_cyc = 0; busy_mask = '0; ack_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) ld_req = 1'b1;
            if (k <= 7) busy_mask[k-1] = busy;
            if (cpu_ack) begin cpu_cyc = k; cpu_req = 1'b0; end
            if (ld_ack) begin
                ld_cyc = k;
                ld_req = 1'b0;
                check_eq("late_ld_rdata", {16'd0, rdata}, 32'hBEEF);
                ack_seen = 1;
            end
            if (ack_seen != 0) break;
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        check_eq("late_cpu_ack_cyc", 32'(cpu_cyc), 32'd3);
        check_eq("late_ld_ack_cyc", 32'(ld_cyc), 32'd7);
        check_eq("late_busy_mask", {25'd0, busy_mask}, {25'd0, 7'b1110111});

        // Reset in the first ACCESS cycle of a CPU read
        @(negedge Clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        @(negedge Clk);
        check_eq("midrst_pre_ce", {31'd0, mem_ce}, 32'd1);
        Reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge Clk);
        Reset   = 1'b0;
        cpu_req = 1'b0;
        ack_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (cpu_ack || ld_ack) ack_n++;
        end
        check_eq("midrst_no_ack", 32'(ack_n), 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
